vend_share_ctrl: RTL and testbench
==================================

Name: vend_share_ctrl

Overview:
- Transaction controller and round-robin arbiter that shares one coffee dispenser between NPORT customer panels.
- Grants one panel at a time and accumulates that panel's coins (denominations 1, 2, 5) into a credit register.
- Fires the dispenser once credit reaches PRICE, then returns the excess as change, one coin per cycle.
- Sits between the front-panel coin acceptors and the dispenser/change-hopper drivers.

Parameters:
- NPORT, 2, number of requesting panels (2..8).
- PRICE, 3, cost of one coffee in coin units (1..15).
- DISP_CYCLES, 4, cycles coffee is held high per vend (>=1).
- TIMEOUT, 16, idle ACCEPT cycles with no valid coin before auto-cancel (>=2).
- CREDIT_W, 5, credit register width; must satisfy 2^CREDIT_W > PRICE+4.

Ports:
- clk  in  1  system clock, rising edge.
- firstinit_n  in  1  asynchronous active-low reset.
- req  in  NPORT  per-panel service request; level, held for the whole transaction.
- coin_in  in  3*NPORT  per-panel coin code, bits [3i+2:3i] for panel i; 0 = no coin.
- cancel  in  NPORT  per-panel cancel, sampled only for the granted panel.
- gnt  out  NPORT  one-hot grant, registered.
- coffee  out  1  dispenser drive, high for DISP_CYCLES cycles.
- rem  out  3  change coin issued this cycle (0, 1 or 2).
- coin_rej  out  1  one-cycle pulse: invalid coin code from the granted panel.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset (firstinit_n low, asynchronous): state IDLE, gnt=0, coffee=0, rem=0, coin_rej=0, busy=0, credit=0, timeout counter=0, rr pointer=0. Reset mid-transaction discards credit; no change is returned.
- All outputs are registered. States: IDLE, ACCEPT, DISPENSE, CHANGE.
- IDLE:
  - If any req bit is high, pick the first requester at or after the rr pointer (wrapping).
  - Next cycle: gnt one-hot for that panel, state ACCEPT, credit=0. rr pointer = winner+1 mod NPORT.
  - Grant latency is 1 cycle. gnt is 0 for at least one IDLE cycle between transactions.
- ACCEPT (only the granted panel's coin_in, cancel and req are observed):
  - Cancel condition: cancel high, or req low. Takes priority over a coin in the same cycle; that coin is not credited.
  - Cancel exits to CHANGE if credit>0, else to IDLE.
  - Valid coin (1, 2, 5): credit += coin, timeout counter cleared.
    - If the new credit >= PRICE: credit <= new credit - PRICE, next state DISPENSE.
  - Codes 3, 4, 6, 7: coin_rej=1 for one cycle, credit unchanged, counter not cleared.
  - Code 0: counter increments. When it reaches TIMEOUT, treat as cancel.
- DISPENSE:
  - coffee=1 for exactly DISP_CYCLES consecutive cycles; coin_in ignored; cancel ignored.
  - Then CHANGE if credit>0, else IDLE.
- CHANGE:
  - Each cycle: rem=2 if credit>=2, else rem=1; credit decremented by rem.
  - On the cycle credit becomes 0, next state IDLE, gnt=0.
  - rem=0 in all other states.
- Non-granted panels' req bits are held pending; no starvation, since every requester is served within NPORT transactions.
- coffee and a nonzero rem are never high in the same cycle.

Test Plan:
- Reset, then assert firstinit_n low during DISPENSE -> coffee, gnt and busy drop immediately; after release, IDLE with credit 0 and no rem pulses.
- req[0]=1, coins 1,1,1 on consecutive cycles -> gnt=01 one cycle after req, coffee high 4 cycles starting the cycle after the third coin, rem stays 0, gnt=00 next.
- req[1]=1, single coin 5 -> coffee high 4 cycles, then rem=2 for one cycle (credit 2), then gnt=00.
- req=11 together after reset -> port 0 served first. After it completes and one IDLE cycle passes, gnt=10. Next simultaneous request starts again at port 0.
- Port 0: coin 2, then cancel together with coin 1 -> no coffee, the coin 1 is not credited, rem=2 for one cycle, then IDLE.
- Port 0: coin code 3 -> coin_rej pulse, credit 0. Then coin 1 followed by 16 idle cycles -> auto-cancel, rem=1 one cycle, then IDLE.

Source files
------------

// File: rtl/vend_share_ctrl_if.sv
// Panel-side signal bundle for the shared coffee dispenser controller.
// master drives requests and coins; slave is the controller.
interface vend_share_ctrl_if #(
   parameter int unsigned NPORT = 2
);
   logic [NPORT-1:0]   req;
   logic [3*NPORT-1:0] coin_in;
   logic [NPORT-1:0]   cancel;
   logic [NPORT-1:0]   gnt;
   logic               coffee;
   logic [2:0]         rem;
   logic               coin_rej;
   logic               busy;

   modport master (
      output req, coin_in, cancel,
      input  gnt, coffee, rem, coin_rej, busy
   );

   modport slave (
      input  req, coin_in, cancel,
      output gnt, coffee, rem, coin_rej, busy
   );
endinterface

// File: rtl/vend_share_ctrl.sv
// Round-robin transaction controller sharing one coffee dispenser between
// NPORT coin panels: grant, accumulate credit, vend, then pay out change.
module vend_share_ctrl #(
   parameter int unsigned NPORT       = 2,
   parameter int unsigned PRICE       = 3,
   parameter int unsigned DISP_CYCLES = 4,
   parameter int unsigned TIMEOUT     = 16,
   parameter int unsigned CREDIT_W    = 5
) (
   input  logic              clk,
   input  logic              firstinit_n,
   vend_share_ctrl_if.slave  bus
);
   localparam int unsigned IDX_W  = (NPORT > 1) ? $clog2(NPORT) : 1;
   localparam int unsigned TCNT_W = $clog2(TIMEOUT + 1);
   localparam int unsigned DCNT_W = (DISP_CYCLES > 1) ? $clog2(DISP_CYCLES) : 1;

   typedef enum logic [1:0] {IDLE, ACCEPT, DISPENSE, CHANGE} state_t;

   state_t              state_q, state_d;
   logic [NPORT-1:0]    gnt_q, gnt_d;
   logic [IDX_W-1:0]    idx_q, idx_d;
   logic [IDX_W-1:0]    rr_q, rr_d;
   logic [CREDIT_W-1:0] credit_q, credit_d;
   logic [TCNT_W-1:0]   tcnt_q, tcnt_d;
   logic [DCNT_W-1:0]   dcnt_q, dcnt_d;
   logic                coffee_q, coffee_d;
   logic [2:0]          rem_q, rem_d;
   logic                rej_q, rej_d;
   logic                busy_q, busy_d;

   logic [2:0]          coin_sel;
   logic                cancel_sel, req_sel;
   logic                any_req, hi_found;
   logic [IDX_W-1:0]    hi_idx, lo_idx, win;
   logic [CREDIT_W-1:0] sum;
   logic                stop, leave;

   function automatic logic [2:0] change_coin(input logic [CREDIT_W-1:0] c);
      return (c >= CREDIT_W'(2)) ? 3'd2 : 3'd1;
   endfunction

   // Only the granted panel's inputs are visible to the transaction logic.
   always_comb begin
      coin_sel   = '0;
      cancel_sel = 1'b0;
      req_sel    = 1'b0;
      for (int i = 0; i < NPORT; i++) begin
         if (idx_q == IDX_W'(i)) begin
            coin_sel   = bus.coin_in[3*i +: 3];
            cancel_sel = bus.cancel[i];
            req_sel    = bus.req[i];
         end
      end
   end

   // Lowest requester at/after the pointer wins; otherwise wrap to the lowest overall.
   always_comb begin
      any_req  = 1'b0;
      hi_found = 1'b0;
      hi_idx   = '0;
      lo_idx   = '0;
      for (int i = NPORT - 1; i >= 0; i--) begin
         if (bus.req[i]) begin
            any_req = 1'b1;
            lo_idx  = IDX_W'(i);
            if (IDX_W'(i) >= rr_q) begin
               hi_found = 1'b1;
               hi_idx   = IDX_W'(i);
            end
         end
      end
      win = hi_found ? hi_idx : lo_idx;
   end

   always_comb begin
      state_d  = state_q;
      gnt_d    = gnt_q;
      idx_d    = idx_q;
      rr_d     = rr_q;
      credit_d = credit_q;
      tcnt_d   = tcnt_q;
      dcnt_d   = dcnt_q;
      rem_d    = '0;
      rej_d    = 1'b0;
      stop     = 1'b0;
      leave    = 1'b0;
      sum      = credit_q + CREDIT_W'(coin_sel);

      case (state_q)
         IDLE: begin
            if (any_req) begin
               state_d  = ACCEPT;
               gnt_d    = NPORT'(1) << win;
               idx_d    = win;
               rr_d     = (win == IDX_W'(NPORT - 1)) ? '0 : win + IDX_W'(1);
               credit_d = '0;
               tcnt_d   = '0;
            end
         end
         ACCEPT: begin
            // Cancel (or a dropped request) beats a coin in the same cycle.
            stop = cancel_sel | ~req_sel;
            if (!stop) begin
               case (coin_sel)
                  3'd1, 3'd2, 3'd5: begin
                     tcnt_d = '0;
                     if (sum >= CREDIT_W'(PRICE)) begin
                        credit_d = sum - CREDIT_W'(PRICE);
                        dcnt_d   = '0;
                        state_d  = DISPENSE;
                     end else begin
                        credit_d = sum;
                     end
                  end
                  3'd0: begin
                     if (tcnt_q == TCNT_W'(TIMEOUT - 1)) stop = 1'b1;
                     else tcnt_d = tcnt_q + TCNT_W'(1);
                  end
                  default: rej_d = 1'b1;
               endcase
            end
            leave = stop;
         end
         DISPENSE: begin
            if (dcnt_q == DCNT_W'(DISP_CYCLES - 1)) leave = 1'b1;
            else dcnt_d = dcnt_q + DCNT_W'(1);
         end
         CHANGE:  leave = 1'b1;
         default: state_d = IDLE;
      endcase

      // credit_q already excludes any coin shown on rem this cycle.
      if (leave) begin
         if (credit_q != '0) begin
            state_d  = CHANGE;
            rem_d    = change_coin(credit_q);
            credit_d = credit_q - CREDIT_W'(rem_d);
         end else begin
            state_d  = IDLE;
            gnt_d    = '0;
            credit_d = '0;
         end
      end

      coffee_d = (state_d == DISPENSE);
      busy_d   = (state_d != IDLE);
   end

   always_ff @(posedge clk or negedge firstinit_n) begin
      if (!firstinit_n) begin
         state_q  <= IDLE;
         gnt_q    <= '0;
         idx_q    <= '0;
         rr_q     <= '0;
         credit_q <= '0;
         tcnt_q   <= '0;
         dcnt_q   <= '0;
         coffee_q <= 1'b0;
         rem_q    <= '0;
         rej_q    <= 1'b0;
         busy_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         gnt_q    <= gnt_d;
         idx_q    <= idx_d;
         rr_q     <= rr_d;
         credit_q <= credit_d;
         tcnt_q   <= tcnt_d;
         dcnt_q   <= dcnt_d;
         coffee_q <= coffee_d;
         rem_q    <= rem_d;
         rej_q    <= rej_d;
         busy_q   <= busy_d;
      end
   end

   assign bus.gnt      = gnt_q;
   assign bus.coffee   = coffee_q;
   assign bus.rem      = rem_q;
   assign bus.coin_rej = rej_q;
   assign bus.busy     = busy_q;
endmodule

// File: tb/tb_vend_share_ctrl.sv
// Bench for vend_share_ctrl: directed scenarios plus random transactions
// predicted by a transaction-level model of credit, vend and change payout.
module tb_vend_share_ctrl;
   localparam int unsigned NPORT       = 2;
   localparam int unsigned PRICE       = 3;
   localparam int unsigned DISP_CYCLES = 4;
   localparam int unsigned TIMEOUT     = 16;
   localparam int unsigned CREDIT_W    = 5;
   localparam int          OW          = NPORT + 6;
   localparam int          CAN         = 8;
   localparam int          DROP        = 16;

   logic clk = 1'b0;
   logic firstinit_n;
   int   checks = 0;
   int   errors = 0;
   int   rr_m   = 0;
   int   script[$];

   always #5 clk = ~clk;

   vend_share_ctrl_if #(.NPORT(NPORT)) bus ();

   vend_share_ctrl #(
      .NPORT(NPORT), .PRICE(PRICE), .DISP_CYCLES(DISP_CYCLES),
      .TIMEOUT(TIMEOUT), .CREDIT_W(CREDIT_W)
   ) dut (
      .clk(clk), .firstinit_n(firstinit_n), .bus(bus)
   );

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic noise(input int skip);
      for (int i = 0; i < NPORT; i++) begin
         if (i != skip) begin
            bus.coin_in[3*i +: 3] = 3'($urandom_range(0, 7));
            bus.cancel[i]         = 1'($urandom_range(0, 1));
         end
      end
   endtask

   task automatic do_reset();
      firstinit_n = 1'b0;
      bus.req     = '0;
      bus.coin_in = '0;
      bus.cancel  = '0;
      repeat (2) @(negedge clk);
      firstinit_n = 1'b1;
      rr_m        = 0;
      script.delete();
   endtask

   // One full transaction: grant, feed script to the winner, then follow vend/change to IDLE.
   task automatic run_txn(input logic [NPORT-1:0] mask, output int w,
                          output logic [NPORT-1:0] gobs, output int ncof,
                          output int nrem, output int nrej);
      logic [OW-1:0]    exp_v, obs_v;
      logic [OW-1:0]    post_q[$];
      logic [NPORT-1:0] gexp;
      int credit, idle, refund, guard, e, coin, r, c;
      bit done, vend, rej;
      ncof = 0; nrem = 0; nrej = 0;
      w = 0;
      for (int k = NPORT - 1; k >= 0; k--)
         if (mask[(rr_m + k) % NPORT]) w = (rr_m + k) % NPORT;
      bus.req = mask;
      noise(-1);
      tick();
      rr_m  = (w + 1) % NPORT;
      gexp  = NPORT'(1) << w;
      gobs  = bus.gnt;
      exp_v = {gexp, 1'b0, 3'd0, 1'b0, 1'b1};
      obs_v = {bus.gnt, bus.coffee, bus.rem, bus.coin_rej, bus.busy};
      checks++;
      if (obs_v !== exp_v) begin
         errors++;
         $display("FAIL grant: got %b need %b (gnt|coffee|rem|rej|busy)", obs_v, exp_v);
      end
      credit = 0; idle = 0; refund = 0; guard = 0; done = 0; vend = 0;
      while (!done && guard < 200) begin
         guard++;
         e    = (script.size() != 0) ? script.pop_front() : 0;
         coin = e & 7;
         noise(w);
         bus.coin_in[3*w +: 3] = 3'(coin);
         bus.cancel[w]         = ((e & CAN) != 0);
         if ((e & DROP) != 0) bus.req[w] = 1'b0;
         tick();
         rej = 0;
         if ((e & (CAN | DROP)) != 0) begin
            done = 1; refund = credit;
         end else if (coin == 1 || coin == 2 || coin == 5) begin
            credit += coin; idle = 0;
            if (credit >= PRICE) begin done = 1; vend = 1; refund = credit - PRICE; end
         end else if (coin == 0) begin
            idle++;
            if (idle == TIMEOUT) begin done = 1; refund = credit; end
         end else begin
            rej = 1;
         end
         nrej += int'(bus.coin_rej);
         if (!done) begin
            exp_v = {gexp, 1'b0, 3'd0, rej, 1'b1};
            obs_v = {bus.gnt, bus.coffee, bus.rem, bus.coin_rej, bus.busy};
            checks++;
            if (obs_v !== exp_v) begin
               errors++;
               $display("FAIL accept cyc%0d: got %b need %b (gnt|coffee|rem|rej|busy)",
                        guard, obs_v, exp_v);
            end
         end
      end
      if (!done) begin
         checks++; errors++;
         $display("FAIL accept_bound: transaction never left ACCEPT, got busy=%b need done", bus.busy);
      end
      if (vend) repeat (DISP_CYCLES) post_q.push_back({gexp, 1'b1, 3'd0, 1'b0, 1'b1});
      r = refund;
      while (r > 0) begin
         c = (r >= 2) ? 2 : 1;
         post_q.push_back({gexp, 1'b0, 3'(c), 1'b0, 1'b1});
         r -= c;
      end
      post_q.push_back('0);
      for (int i = 0; i < post_q.size(); i++) begin
         if (i > 0) begin
            noise(-1);
            tick();
         end
         ncof += int'(bus.coffee);
         nrem += int'(bus.rem);
         obs_v = {bus.gnt, bus.coffee, bus.rem, bus.coin_rej, bus.busy};
         checks++;
         if (obs_v !== post_q[i]) begin
            errors++;
            $display("FAIL post cyc%0d: got %b need %b (gnt|coffee|rem|rej|busy)", i, obs_v, post_q[i]);
         end
      end
   endtask

   task automatic test_reset();
      logic [OW-1:0] obs_v;
      firstinit_n = 1'b0;
      bus.req = '1; bus.coin_in = '0; bus.cancel = '0;
      repeat (2) @(negedge clk);
      obs_v = {bus.gnt, bus.coffee, bus.rem, bus.coin_rej, bus.busy};
      checks++;
      if (obs_v !== '0) begin
         errors++;
         $display("FAIL reset_held: got %b need 0", obs_v);
      end
      bus.req = '0;
      firstinit_n = 1'b1;
      rr_m = 0;
      tick();
      obs_v = {bus.gnt, bus.coffee, bus.rem, bus.coin_rej, bus.busy};
      checks++;
      if (obs_v !== '0) begin
         errors++;
         $display("FAIL reset_idle: got %b need 0", obs_v);
      end
   endtask

   task automatic test_exact_coins();
      int w, nc, nr, nj; logic [NPORT-1:0] g;
      do_reset();
      script = '{1, 1, 1};
      run_txn(2'b01, w, g, nc, nr, nj);
      checks++;
      if (nc != DISP_CYCLES || nr != 0) begin
         errors++;
         $display("FAIL exact_coins: got coffee=%0d rem_sum=%0d need %0d/0", nc, nr, DISP_CYCLES);
      end
      bus.req = '0;
      tick();
      checks++;
      if (bus.gnt !== '0 || bus.busy !== 1'b0) begin
         errors++;
         $display("FAIL idle_gap: got gnt=%b busy=%b need 00/0", bus.gnt, bus.busy);
      end
   endtask

   task automatic test_coin5_change();
      int w, nc, nr, nj; logic [NPORT-1:0] g;
      script = '{5};
      run_txn(2'b10, w, g, nc, nr, nj);
      checks++;
      if (g !== 2'b10 || nc != DISP_CYCLES || nr != 2) begin
         errors++;
         $display("FAIL coin5_change: got gnt=%b coffee=%0d rem_sum=%0d need 10/%0d/2",
                  g, nc, nr, DISP_CYCLES);
      end
      bus.req = '0;
      tick();
   endtask

   task automatic test_round_robin();
      int w, nc, nr, nj; logic [NPORT-1:0] g;
      logic [NPORT-1:0] need[3];
      need[0] = 2'b01; need[1] = 2'b10; need[2] = 2'b01;
      do_reset();
      for (int t = 0; t < 3; t++) begin
         script = '{1, 2};
         run_txn(2'b11, w, g, nc, nr, nj);
         checks++;
         if (g !== need[t]) begin
            errors++;
            $display("FAIL round_robin t%0d: got gnt=%b need %b", t, g, need[t]);
         end
      end
      bus.req = '0;
      tick();
   endtask

   task automatic test_cancel();
      int w, nc, nr, nj; logic [NPORT-1:0] g;
      do_reset();
      script = '{2, CAN | 1};
      run_txn(2'b01, w, g, nc, nr, nj);
      checks++;
      if (nc != 0 || nr != 2) begin
         errors++;
         $display("FAIL cancel: got coffee=%0d rem_sum=%0d need 0/2", nc, nr);
      end
      bus.req = '0;
      tick();
   endtask

   task automatic test_reject_timeout();
      int w, nc, nr, nj; logic [NPORT-1:0] g;
      do_reset();
      script = '{3, 1};
      run_txn(2'b01, w, g, nc, nr, nj);
      checks++;
      if (nj != 1 || nc != 0 || nr != 1) begin
         errors++;
         $display("FAIL reject_timeout: got rej=%0d coffee=%0d rem_sum=%0d need 1/0/1", nj, nc, nr);
      end
      bus.req = '0;
      tick();
   endtask

   task automatic test_reset_dispense();
      do_reset();
      bus.req = 2'b01;
      tick();
      bus.coin_in[2:0] = 3'd5;
      tick();
      checks++;
      if (bus.coffee !== 1'b1) begin
         errors++;
         $display("FAIL dispense_start: got coffee=%b need 1", bus.coffee);
      end
      tick();
      #2 firstinit_n = 1'b0;
      #1;
      checks++;
      if (bus.coffee !== 1'b0 || bus.gnt !== '0 || bus.busy !== 1'b0) begin
         errors++;
         $display("FAIL async_reset: got coffee=%b gnt=%b busy=%b need 0/00/0",
                  bus.coffee, bus.gnt, bus.busy);
      end
      bus.req = '0;
      bus.coin_in = '0;
      @(negedge clk);
      firstinit_n = 1'b1;
      rr_m = 0;
      for (int i = 0; i < 4; i++) begin
         tick();
         checks++;
         if (bus.rem !== 3'd0 || bus.gnt !== '0 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL post_reset cyc%0d: got rem=%0d gnt=%b busy=%b need 0/00/0",
                     i, bus.rem, bus.gnt, bus.busy);
         end
      end
   endtask

   task automatic test_random();
      int w, nc, nr, nj, len, r;
      logic [NPORT-1:0] g, mask;
      int valid[3];
      int bad[4];
      valid = '{1, 2, 5};
      bad   = '{3, 4, 6, 7};
      do_reset();
      for (int t = 0; t < 30; t++) begin
         mask = NPORT'($urandom_range(1, (1 << NPORT) - 1));
         script.delete();
         len = $urandom_range(1, 6);
         for (int k = 0; k < len; k++) begin
            r = $urandom_range(0, 9);
            if (r <= 5)      script.push_back(valid[$urandom_range(0, 2)]);
            else if (r == 6) script.push_back(0);
            else if (r == 7) script.push_back(bad[$urandom_range(0, 3)]);
            else if (r == 8) script.push_back(CAN | $urandom_range(0, 7));
            else             script.push_back(DROP | $urandom_range(0, 7));
         end
         run_txn(mask, w, g, nc, nr, nj);
      end
      bus.req = '0;
      tick();
   endtask

   initial begin
      firstinit_n = 1'b0;
      bus.req = '0; bus.coin_in = '0; bus.cancel = '0;
      test_reset();
      test_exact_coins();
      test_coin5_change();
      test_round_robin();
      test_cancel();
      test_reject_timeout();
      test_reset_dispense();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
